ofmap_writer: RTL and testbench

OFMAP_WRITER -- requirements
Module: ofmap_writer

---
 rtl/ofmap_pkg.sv | 13 +
 rtl/ofmap_writer_requant.sv | 53 +++++
 rtl/ofmap_writer.sv | 146 ++++++++++++++
 tb/tb_ofmap_writer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofmap_pkg.sv
// Shared types and default sizes for the output-feature-map writer.
package ofmap_pkg;

  localparam int unsigned ODWIDTH_DEF = 8;
  localparam int unsigned PACK_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/ofmap_writer_requant.sv
// Requantizer: round-half-up right shift, optional ReLU, saturate, one register stage.
module requant
  import ofmap_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned ODWIDTH = ODWIDTH_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               valid,
  input  logic [DWIDTH-1:0]  data,
  input  logic [4:0]         shift,
  input  logic               relu,
  output logic               q_valid,
  output logic [ODWIDTH-1:0] q
);

  localparam int unsigned RW = DWIDTH + 1;
  localparam logic signed [DWIDTH:0] MAXV =
    signed'({{(DWIDTH-ODWIDTH+2){1'b0}}, {(ODWIDTH-1){1'b1}}});
  localparam logic signed [DWIDTH:0] MINV =
    signed'({{(DWIDTH-ODWIDTH+2){1'b1}}, {(ODWIDTH-1){1'b0}}});

  logic signed [DWIDTH:0] ext;
  logic signed [DWIDTH:0] rnd;
  logic signed [DWIDTH:0] v;
  logic [ODWIDTH-1:0]     qn;

  always_comb begin
    ext = signed'({data[DWIDTH-1], data});
    rnd = '0;
    v   = ext;
    if (shift != '0) begin
      rnd = signed'(RW'(1) << (shift - 5'd1));
      v   = (ext + rnd) >>> shift;
    end
    if (relu && v[DWIDTH]) v = '0;
    if (v > MAXV)      qn = MAXV[ODWIDTH-1:0];
    else if (v < MINV) qn = MINV[ODWIDTH-1:0];
    else               qn = v[ODWIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else begin
      q_valid <= valid;
      if (valid) q <= qn;
    end
  end

endmodule

// File: rtl/ofmap_writer.sv
// Output-feature-map writer: requantizes a tile of results and packs them into buffer words.
module ofmap_writer
  import ofmap_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned ODWIDTH = ODWIDTH_DEF,
  parameter int unsigned PACK    = PACK_DEF,
  parameter int unsigned AWIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cfg_start,
  input  logic [4:0]                cfg_shift,
  input  logic                      cfg_relu,
  input  logic [AWIDTH-1:0]         cfg_base,
  input  logic [AWIDTH+1:0]         cfg_count,
  input  logic                      result_valid,
  input  logic [DWIDTH-1:0]         result,
  output logic                      wr_en,
  output logic [AWIDTH-1:0]         wr_addr,
  output logic [ODWIDTH*PACK-1:0]   wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned WW = ODWIDTH * PACK;
  localparam int unsigned LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned CW = AWIDTH + 2;

  state_t             state;
  logic [4:0]         shift_r;
  logic               relu_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      elem_cnt;
  logic [LW-1:0]      lane;
  logic [WW-1:0]      pack;
  logic [WW-1:0]      pack_next;
  logic [AWIDTH-1:0]  addr_cnt;
  logic               accept;
  logic               last_beat;
  logic               q_last;
  logic               q_valid;
  logic [ODWIDTH-1:0] q;
  logic               word_done;

  requant #(
    .DWIDTH (DWIDTH),
    .ODWIDTH(ODWIDTH)
  ) u_requant (
    .clk    (clk),
    .rstn   (rstn),
    .valid  (accept),
    .data   (result),
    .shift  (shift_r),
    .relu   (relu_r),
    .q_valid(q_valid),
    .q      (q)
  );

  always_comb begin
    accept    = (state == RUN) && result_valid;
    last_beat = accept && (elem_cnt == count_r - CW'(1));
    pack_next = pack;
    for (int unsigned i = 0; i < PACK; i++) begin
      if (lane == LW'(i)) pack_next[i*ODWIDTH +: ODWIDTH] = q;
    end
    word_done = q_valid && ((lane == LW'(PACK - 1)) || q_last);
  end

  // q_last travels alongside the requant register so the pack stage knows the tile's final element.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      shift_r  <= '0;
      relu_r   <= 1'b0;
      count_r  <= '0;
      elem_cnt <= '0;
      lane     <= '0;
      pack     <= '0;
      addr_cnt <= '0;
      q_last   <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      done   <= 1'b0;
      q_last <= last_beat;

      case (state)
        IDLE: begin
          if (cfg_start) begin
            shift_r  <= cfg_shift;
            relu_r   <= cfg_relu;
            count_r  <= cfg_count;
            addr_cnt <= cfg_base;
            elem_cnt <= '0;
            lane     <= '0;
            pack     <= '0;
            if (cfg_count == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            elem_cnt <= elem_cnt + CW'(1);
            if (last_beat) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if ((cfg_start && state != IDLE) || (result_valid && state != RUN)) err <= 1'b1;

      if (q_valid) begin
        if (word_done) begin
          wr_en    <= 1'b1;
          wr_data  <= pack_next;
          wr_addr  <= addr_cnt;
          addr_cnt <= addr_cnt + AWIDTH'(1);
          pack     <= '0;
          lane     <= '0;
          if (q_last) done <= 1'b1;
        end else begin
          pack <= pack_next;
          lane <= lane + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ofmap_writer.sv
// Self-checking bench for ofmap_writer: scheduled-write model plus literal write-log checks.
module tb_ofmap_writer;

  localparam int N = 1024;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cfg_start = 1'b0;
  logic [4:0]        cfg_shift = '0;
  logic              cfg_relu = 1'b0;
  logic [9:0]        cfg_base = '0;
  logic [11:0]       cfg_count = '0;
  logic              result_valid = 1'b0;
  logic [31:0]       result = '0;
  logic              wr_en;
  logic [9:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;

  ofmap_writer #(
    .DWIDTH (32),
    .ODWIDTH(8),
    .PACK   (4),
    .AWIDTH (10)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_start   (cfg_start),
    .cfg_shift   (cfg_shift),
    .cfg_relu    (cfg_relu),
    .cfg_base    (cfg_base),
    .cfg_count   (cfg_count),
    .result_valid(result_valid),
    .result      (result),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected behaviour per cycle index
  bit          exp_wr   [N];
  bit          exp_done [N];
  bit          exp_busy [N];
  logic [9:0]  exp_addr [N];
  logic [31:0] exp_data [N];
  int          err_from = 1 << 30;

  int n_cmp = 0;
  int n_bad = 0;
  logic [41:0] log_q[$];

  // Abstract tile model
  bit         m_acc = 1'b0;
  int         m_lane, m_cnt, m_total, m_sh;
  bit         m_rl;
  logic [31:0] m_word;
  logic [9:0]  m_addr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic logic [7:0] quant(input longint r, input int s, input bit relu);
    longint v;
    if (s > 0) v = (r + (longint'(1) << (s - 1))) >>> s;
    else       v = r;
    if (relu && v < 0) v = 0;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      chk("rst_wr_addr", {54'd0, wr_addr}, 64'd0);
      chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
    end else if (cyc < N) begin
      chk("wr_en", {63'd0, wr_en}, {63'd0, exp_wr[cyc]});
      chk("done", {63'd0, done}, {63'd0, exp_done[cyc]});
      chk("busy", {63'd0, busy}, {63'd0, exp_busy[cyc]});
      chk("err", {63'd0, err}, {63'd0, (cyc >= err_from)});
      if (exp_wr[cyc] && wr_en) begin
        chk("wr_addr", {54'd0, wr_addr}, {54'd0, exp_addr[cyc]});
        chk("wr_data", {32'd0, wr_data}, {32'd0, exp_data[cyc]});
      end
      if (wr_en) log_q.push_back({wr_addr, wr_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flag_err(input int k);
    if (k + 1 < err_from) err_from = k + 1;
  endtask

  task automatic drive(input bit v, input int r, input bit st,
                       input int sh = 0, input bit rl = 1'b0, input int base = 0, input int cnt = 0);
    int k;
    logic [7:0] qv;
    k = cyc;
    result_valid = v;
    result       = r;
    cfg_start    = st;
    cfg_shift    = sh[4:0];
    cfg_relu     = rl;
    cfg_base     = base[9:0];
    cfg_count    = cnt[11:0];
    if (v) begin
      if (!m_acc) begin
        flag_err(k);
      end else begin
        qv = quant(longint'(r), m_sh, m_rl);
        m_word[8*m_lane +: 8] = qv;
        m_lane++;
        m_cnt++;
        if ((m_lane == 4 || m_cnt == m_total) && k + 2 < N) begin
          exp_wr[k+2]   = 1'b1;
          exp_addr[k+2] = m_addr;
          exp_data[k+2] = m_word;
          m_addr = m_addr + 10'd1;
          m_word = '0;
          m_lane = 0;
        end
        if (m_cnt == m_total) begin
          m_acc = 1'b0;
          if (k + 2 < N) exp_done[k+2] = 1'b1;
          for (int j = k + 3; j < N; j++) exp_busy[j] = 1'b0;
        end
      end
    end
    if (st) begin
      if (exp_busy[k]) begin
        flag_err(k);
      end else if (cnt == 0) begin
        if (k + 1 < N) exp_done[k+1] = 1'b1;
      end else begin
        m_acc = 1'b1; m_cnt = 0; m_total = cnt; m_lane = 0; m_word = '0;
        m_addr = base[9:0]; m_sh = sh; m_rl = rl;
        for (int j = k + 1; j < N; j++) exp_busy[j] = 1'b1;
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    int k;
    k = cyc;
    rstn = 1'b0;
    result_valid = 1'b0;
    cfg_start = 1'b0;
    for (int j = k; j < N; j++) begin
      exp_wr[j] = 1'b0; exp_done[j] = 1'b0; exp_busy[j] = 1'b0;
    end
    m_acc = 1'b0;
    err_from = 1 << 30;
    repeat (hold) tick();
    rstn = 1'b1;
  endtask

  logic [41:0] lit[7];

  initial begin
    lit[0] = {10'h010, 32'h807FFA06};
    lit[1] = {10'h020, 32'h04030201};
    lit[2] = {10'h021, 32'h00000605};
    lit[3] = {10'h3FF, 32'h807F0201};
    lit[4] = {10'h000, 32'h057F80FF};
    lit[5] = {10'h100, 32'h00050400};
    lit[6] = {10'h200, 32'h0000140A};

    repeat (3) tick();
    rstn = 1'b1;
    idle(2);

    // Rounding and saturation in both directions, one full word
    drive(1'b0, 0, 1'b1, 4, 1'b0, 'h010, 4);
    drive(1'b1, 100, 1'b0);
    drive(1'b1, -100, 1'b0);
    drive(1'b1, 5000, 1'b0);
    drive(1'b1, -5000, 1'b0);
    idle(4);

    // Gapped input with ReLU, partial final word
    drive(1'b0, 0, 1'b1, 0, 1'b1, 'h020, 6);
    drive(1'b1, 1, 1'b0);
    idle(1);
    drive(1'b1, 2, 1'b0);
    drive(1'b1, 3, 1'b0);
    idle(2);
    drive(1'b1, 4, 1'b0);
    drive(1'b1, 5, 1'b0);
    idle(1);
    drive(1'b1, 6, 1'b0);
    idle(4);

    // Address wrap at the top of the buffer, then a back-to-back tile
    drive(1'b0, 0, 1'b1, 0, 1'b0, 'h3FF, 8);
    drive(1'b1, 1, 1'b0);
    drive(1'b1, 2, 1'b0);
    drive(1'b1, 300, 1'b0);
    drive(1'b1, -300, 1'b0);
    drive(1'b1, -1, 1'b0);
    drive(1'b1, -128, 1'b0);
    drive(1'b1, 127, 1'b0);
    drive(1'b1, 5, 1'b0);
    idle(2);
    drive(1'b0, 0, 1'b1, 1, 1'b1, 'h100, 3);
    drive(1'b1, -7, 1'b0);
    drive(1'b1, 7, 1'b0);
    drive(1'b1, 9, 1'b0);
    idle(4);

    // Empty tile
    drive(1'b0, 0, 1'b1, 0, 1'b0, 'h050, 0);
    chk("zero_count_done", {63'd0, done}, 64'd1);
    idle(3);

    // Reset mid-tile
    drive(1'b0, 0, 1'b1, 0, 1'b0, 'h300, 4);
    drive(1'b1, 11, 1'b0);
    drive(1'b1, 12, 1'b0);
    do_reset(2);
    idle(6);
    chk("reset_midtile_busy", {63'd0, busy}, 64'd0);
    chk("reset_midtile_err", {63'd0, err}, 64'd0);

    // Protocol errors: beat in IDLE, start in RUN, beat in FLUSH
    drive(1'b1, 55, 1'b0);
    drive(1'b0, 0, 1'b1, 0, 1'b0, 'h200, 2);
    drive(1'b1, 10, 1'b0);
    drive(1'b0, 0, 1'b1, 3, 1'b1, 'h000, 7);
    drive(1'b1, 20, 1'b0);
    drive(1'b1, 99, 1'b0);
    idle(6);
    chk("err_sticky", {63'd0, err}, 64'd1);
    do_reset(2);
    idle(2);
    chk("err_cleared", {63'd0, err}, 64'd0);

    chk("write_count", 64'(log_q.size()), 64'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < log_q.size()) chk($sformatf("write_%0d", i), {22'd0, log_q[i]}, {22'd0, lit[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
